cereal_arbiter: RTL and testbench
=================================

Name: cereal_arbiter

Overview:
- Round-robin arbiter that shares one serial byte transmitter between NREQ byte sources.
- The transmitter uses the data / start / status (1 = ready) handshake.
- The arbiter picks a requester, drives the transmitter's data and start, and tracks the transmitter's status through one frame. It then acknowledges the requester, so each accepted byte produces exactly one frame.
- A start timeout catches a stalled or absent transmitter and raises a sticky error.

Parameters:
- NREQ, 4, number of requesters (2..8).
- START_TIMEOUT, 12000, sysclk cycles to wait in LAUNCH for the transmitter to go busy. Covers two bit periods at 5208 cycles/bit.
- CNT_W, 16, width of the sent-byte counter.

Ports:
- sysclk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester byte-available flag.
- req_data  in  8*NREQ  requester i byte at [8i+7:8i].
- req_ack  out  NREQ  one-cycle pulse: byte i transmitted.
- tx_data  out  8  byte to the transmitter.
- tx_start  out  1  start request to the transmitter.
- tx_status  in  1  transmitter status, 1 = ready/idle. Generated on a divided clock, so it is synchronised here.
- err_clr  in  1  clears err.
- grant_id  out  3  index of the current or last granted requester.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky timeout flag.
- byte_cnt  out  CNT_W  frames completed, wraps.

Behaviour:
- Reset (async, active-high, any state):
  - state=IDLE; all outputs 0.
  - rr_ptr=NREQ-1, so requester 0 wins first.
  - Timeout counter 0; status synchroniser flops preset to 1.
  - Reset mid-frame drops tx_start immediately; no ack is issued for the aborted byte.
- tx_status passes through a 2-flop synchroniser giving st_s. All decisions use st_s (2-cycle latency).
- Requester contract: hold req_valid and req_data stable until its req_ack pulse. Dropping req_valid before the ack is illegal; the byte already latched is still sent.
- IDLE:
  - If any req_valid, grant the first valid index searching rr_ptr+1, rr_ptr+2, … mod NREQ.
  - Latch req_data[g] into tx_data, set grant_id=g, clear the timeout counter, go to LAUNCH (1 cycle after valid seen).
  - With no req_valid, remain in IDLE with tx_start=0.
- LAUNCH:
  - tx_start=1; tx_data held; counter increments.
  - If st_s==0: go to WAIT_DONE.
  - Else if counter==START_TIMEOUT-1: set err, rr_ptr=g, go to IDLE with no ack. The requester retries on its next turn.
- WAIT_DONE:
  - tx_start=0, since a held start would queue a second frame; tx_data stays held.
  - When st_s==1: go to ACK. No timeout in this state.
- ACK (1 cycle):
  - req_ack[g]=1, byte_cnt+=1 (wraps at 2^CNT_W), rr_ptr=g, go to IDLE.
- grant_id keeps its last value in IDLE.
- tx_data changes only on a grant in IDLE.
- err:
  - Set on timeout, cleared by err_clr.
  - If both occur in the same cycle, set wins.
  - err never blocks arbitration.
- Exactly one req_ack bit can be high at a time, and only in ACK.
- Minimum IDLE-to-IDLE per byte: 1 (IDLE) + LAUNCH until st_s low + WAIT_DONE + 1 (ACK).

Test Plan:
- Single requester: req_valid=0001, req_data[7:0]=8'h41, transmitter model goes busy 20 cycles after start and ready 200 cycles later.
  - tx_data=41 and tx_start=1 from the cycle after valid until st_s low.
  - Exactly one req_ack[0] pulse after st_s returns high; byte_cnt=1; busy then low.
- Round-robin fairness: req_valid=1111 held, bytes 10/11/12/13.
  - Grant order is 0,1,2,3,0.
  - After ack of 3 with all still valid, 0 is granted; every index gets one grant per 4 frames.
- Timeout: tx_status stuck at 1, START_TIMEOUT=50, req_valid=0010.
  - err rises after 50 LAUNCH cycles; no ack; FSM returns to IDLE and re-grants 1.
  - err_clr pulse clears err; err_clr in the same cycle as a new timeout leaves err=1.
- No double frame: model holds status low 300 cycles.
  - tx_start is low throughout WAIT_DONE; exactly one busy period is seen per ack; byte_cnt increments once.
- Async reset mid-frame: assert reset during WAIT_DONE with grant 2.
  - tx_start, busy, req_ack and grant_id are 0 within the same cycle; no ack for 2.
  - After release with req_valid=0101, requester 0 is granted first.
- byte_cnt wrap: CNT_W=4, 17 frames → byte_cnt=1.

Source files
------------

// File: rtl/cereal_if.sv
// Requester and transmitter signals shared by the serial byte arbiter.
// master = arbiter side, slave = requesters plus transmitter side.
interface cereal_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ack;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_status;

  modport master (
    input  req_valid,
    input  req_data,
    input  tx_status,
    output req_ack,
    output tx_data,
    output tx_start
  );

  modport slave (
    output req_valid,
    output req_data,
    output tx_status,
    input  req_ack,
    input  tx_data,
    input  tx_start
  );
endinterface

// File: rtl/cereal_arbiter.sv
// Round-robin arbiter sharing one serial byte transmitter between
// NREQ sources; one frame per accepted byte, sticky start timeout.
module cereal_arbiter #(
  parameter int NREQ          = 4,
  parameter int START_TIMEOUT = 12000,
  parameter int CNT_W         = 16
) (
  input  logic             sysclk,
  input  logic             reset,
  cereal_if.master         bus,
  input  logic             err_clr,
  output logic [2:0]       grant_id,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] byte_cnt
);
  localparam int TW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_DONE,
    ACK
  } state_t;

  state_t        state;
  state_t        nstate;
  logic          st_m;
  logic          st_s;
  logic [2:0]    rr_ptr;
  logic [2:0]    pick;
  logic          hit;
  logic [TW-1:0] tcnt;
  logic [7:0]    data_q;
  logic          grant;
  logic          tmo;
  logic          ack;

  // tx_status comes from a divided clock domain; preset to ready
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      st_m <= 1'b1;
      st_s <= 1'b1;
    end else begin
      st_m <= bus.tx_status;
      st_s <= st_m;
    end
  end

  // Highest offset first so the nearest valid index after rr_ptr wins
  always_comb begin
    hit  = 1'b0;
    pick = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (bus.req_valid[(int'(rr_ptr) + k) % NREQ]) begin
        hit  = 1'b1;
        pick = 3'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    grant  = 1'b0;
    tmo    = 1'b0;
    ack    = 1'b0;
    unique case (state)
      IDLE: begin
        if (hit) begin
          grant  = 1'b1;
          nstate = LAUNCH;
        end
      end
      LAUNCH: begin
        if (!st_s) begin
          nstate = WAIT_DONE;
        end else if (tcnt == TW'(START_TIMEOUT - 1)) begin
          tmo    = 1'b1;
          nstate = IDLE;
        end
      end
      WAIT_DONE: begin
        if (st_s) nstate = ACK;
      end
      ACK: begin
        ack    = 1'b1;
        nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      rr_ptr   <= 3'(NREQ - 1);
      grant_id <= '0;
      data_q   <= '0;
      tcnt     <= '0;
      err      <= 1'b0;
      byte_cnt <= '0;
    end else begin
      if (grant) begin
        grant_id <= pick;
        data_q   <= bus.req_data[int'(pick)*8 +: 8];
        tcnt     <= '0;
      end
      if (state == LAUNCH) tcnt <= tcnt + 1'b1;
      if (tmo || ack)      rr_ptr <= grant_id;
      if (ack)             byte_cnt <= byte_cnt + 1'b1;
      // A timeout in the same cycle as a clear must stay visible
      if (tmo)          err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

  assign bus.tx_start = (state == LAUNCH);
  assign bus.tx_data  = data_q;
  assign busy         = (state != IDLE);
  assign bus.req_ack  = ack ? (NREQ'(1) << grant_id) : '0;

endmodule

// File: tb/tb_cereal_arbiter.sv
// Bench for cereal_arbiter: transmitter model, event-level
// round-robin model, and directed scenarios with literal checks.
module tb_cereal_arbiter;
  localparam int NREQ = 4;
  localparam int TMO  = 50;
  localparam int CW   = 4;

  logic          sysclk = 1'b0;
  logic          reset  = 1'b1;
  logic          err_clr = 1'b0;
  logic [2:0]    grant_id;
  logic          busy;
  logic          err;
  logic [CW-1:0] byte_cnt;

  cereal_if #(.NREQ(NREQ)) bus ();

  cereal_arbiter #(
    .NREQ(NREQ),
    .START_TIMEOUT(TMO),
    .CNT_W(CW)
  ) dut (
    .sysclk(sysclk),
    .reset(reset),
    .bus(bus),
    .err_clr(err_clr),
    .grant_id(grant_id),
    .busy(busy),
    .err(err),
    .byte_cnt(byte_cnt)
  );

  always #5 sysclk = ~sysclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // transmitter model: 0 ready, 1 pending, 2 busy
  int txm = 0;
  int txc = 0;
  int el = 0;
  int pend_n = 20;
  int busy_n = 200;
  int frames = 0;
  bit stuck = 1'b0;

  // round-robin model state, tracked from observed events
  int rr_m = NREQ - 1;
  int g_m = 0;
  logic [7:0] d_m = '0;
  int cnt_m = 0;
  bit err_exp = 1'b0;
  logic [NREQ-1:0] pv = '0;
  logic [8*NREQ-1:0] pd = '0;
  bit pbusy = 1'b0;
  bit pack = 1'b0;
  bit pclr = 1'b0;
  int run = 0;
  int e_m;
  bit tmo_seen;

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.tx_status = 1'b1;
  end

  always @(negedge sysclk) begin
    if (reset) begin
      rr_m = NREQ - 1;
      g_m = 0;
      d_m = '0;
      cnt_m = 0;
      err_exp = 1'b0;
      frames = 0;
      pbusy = 1'b0;
      pack = 1'b0;
      pclr = 1'b0;
      run = 0;
    end else begin
      if (busy && !pbusy) begin
        e_m = -1;
        for (int k = NREQ; k >= 1; k--)
          if (pv[(rr_m + k) % NREQ]) e_m = (rr_m + k) % NREQ;
        if (e_m < 0) begin
          expire("grant_without_valid");
        end else begin
          g_m = e_m;
          d_m = pd[8*e_m +: 8];
        end
      end
      tmo_seen = !busy && pbusy && !pack;
      if (tmo_seen) begin
        chk("timeout_len", run, TMO);
        rr_m = g_m;
      end
      err_exp = tmo_seen ? 1'b1 : (pclr ? 1'b0 : err_exp);
      chk("err", err, err_exp);
      chk("grant_id", grant_id, g_m);
      chk("tx_data", bus.tx_data, d_m);
      chk("byte_cnt", byte_cnt, cnt_m % (1 << CW));
      if (|bus.req_ack) begin
        chk("ack_onehot", bus.req_ack, 1 << g_m);
        chk("ack_busy", busy, 1);
        chk("frames_per_ack", frames, 1);
        frames = 0;
        rr_m = g_m;
        cnt_m++;
      end
      if (bus.tx_start && txm == 2)
        chk("start_in_wait", el > 4, 0);
      run = bus.tx_start ? run + 1 : 0;
      pbusy = busy;
      pack = |bus.req_ack;
      pclr = err_clr;
    end
    pv = bus.req_valid;
    pd = bus.req_data;
    if (stuck) begin
      txm = 0;
      bus.tx_status = 1'b1;
    end else begin
      case (txm)
        0: begin
          bus.tx_status = 1'b1;
          if (bus.tx_start) begin
            frames++;
            txm = 1;
            txc = pend_n;
          end
        end
        1: begin
          txc--;
          if (txc <= 0) begin
            txm = 2;
            txc = busy_n;
            el = 0;
            bus.tx_status = 1'b0;
          end
        end
        default: begin
          el++;
          txc--;
          if (txc <= 0) begin
            txm = 0;
            bus.tx_status = 1'b1;
          end
        end
      endcase
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge sysclk);
    #1 reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic wait_ack(input int budget, output int idx);
    idx = -1;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (|bus.req_ack) begin
        for (int k = 0; k < NREQ; k++)
          if (bus.req_ack[k]) idx = k;
        break;
      end
    end
    if (idx < 0) expire("ack_wait");
  endtask

  task automatic wait_busy(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (busy) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) expire("busy_wait");
  endtask

  task automatic wait_txm(input int st, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (txm == st) begin
        seen = 1'b1;
        break;
      end
      tick(1);
    end
    if (!seen) expire("tx_model_wait");
  endtask

  int idx;
  int got[5];
  int exp_ord[5] = '{0, 1, 2, 3, 0};

  initial begin
    tick(3);
    chk("rst_busy", busy, 0);
    chk("rst_start", bus.tx_start, 0);
    chk("rst_ack", bus.req_ack, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", byte_cnt, 0);
    chk("rst_data", bus.tx_data, 0);
    reset = 1'b0;

    // single requester
    pend_n = 20;
    busy_n = 200;
    tick(2);
    bus.req_data[7:0] = 8'h41;
    bus.req_valid = 4'b0001;
    tick(1);
    chk("t1_start", bus.tx_start, 1);
    chk("t1_data", bus.tx_data, 8'h41);
    wait_ack(1000, idx);
    bus.req_valid = '0;
    chk("t1_ack_id", idx, 0);
    tick(3);
    chk("t1_cnt", byte_cnt, 1);
    chk("t1_busy", busy, 0);

    // round-robin fairness
    wait_txm(0, 1000);
    do_reset();
    pend_n = 5;
    busy_n = 30;
    bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_ack(500, got[i]);
      if (i == 4) bus.req_valid = '0;
    end
    for (int i = 0; i < 5; i++)
      chk($sformatf("t2_order%0d", i), got[i], exp_ord[i]);

    // start timeout, clear, and clear colliding with timeout
    wait_txm(0, 1000);
    do_reset();
    stuck = 1'b1;
    bus.req_data[15:8] = 8'h77;
    bus.req_valid = 4'b0010;
    wait_busy(20);
    chk("t3_grant", grant_id, 1);
    tick(49);
    chk("t3_err_early", err, 0);
    chk("t3_busy_early", busy, 1);
    tick(1);
    chk("t3_err_set", err, 1);
    chk("t3_idle", busy, 0);
    tick(1);
    chk("t3_regrant_busy", busy, 1);
    chk("t3_regrant_id", grant_id, 1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("t3_err_clr", err, 0);
    tick(48);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    bus.req_valid = '0;
    chk("t3_set_wins", err, 1);
    chk("t3_idle2", busy, 0);
    stuck = 1'b0;

    // long busy transmitter: one frame per ack
    do_reset();
    pend_n = 3;
    busy_n = 300;
    bus.req_data[23:16] = 8'h5A;
    bus.req_valid = 4'b0100;
    wait_ack(1000, idx);
    bus.req_valid = '0;
    chk("t4_ack_id", idx, 2);
    tick(3);
    chk("t4_cnt", byte_cnt, 1);

    // async reset in WAIT_DONE
    wait_txm(0, 1000);
    do_reset();
    bus.req_data[23:16] = 8'hC3;
    bus.req_valid = 4'b0100;
    wait_busy(20);
    wait_txm(2, 100);
    tick(50);
    chk("t5_grant", grant_id, 2);
    chk("t5_wait_start", bus.tx_start, 0);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_start", bus.tx_start, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ack", bus.req_ack, 0);
    chk("t5_rst_grant", grant_id, 0);
    bus.req_data[7:0] = 8'h11;
    bus.req_valid = 4'b0101;
    wait_txm(0, 1000);
    @(posedge sysclk);
    #1 reset = 1'b0;
    wait_ack(1000, idx);
    chk("t5_first", idx, 0);
    wait_ack(1000, idx);
    bus.req_valid = '0;
    chk("t5_second", idx, 2);

    // counter wrap at 2^CW
    wait_txm(0, 1000);
    do_reset();
    pend_n = 2;
    busy_n = 5;
    bus.req_data[31:24] = 8'h55;
    bus.req_valid = 4'b1000;
    for (int i = 0; i < 17; i++) begin
      wait_ack(200, idx);
      if (i == 16) bus.req_valid = '0;
    end
    tick(3);
    chk("t6_wrap", byte_cnt, 1);
    chk("t6_err", err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
